// File: rtl/pu_mux_n.sv
// N-channel multiplexer processing unit: a selector word picks one of N data slots, signal_oe emits it.
// Build option PU_MUX_N_REG_OUT_EN registers data_out/attr_out (one-cycle pulse after signal_oe).
module pu_mux_n #(
    parameter int W    = 32,
    parameter int WA   = 4,
    parameter int N    = 4,
    parameter int SELW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          signal_load,
    input  logic          signal_sel,
    input  logic [1:0]    signal_mode,
    input  logic [W-1:0]  data_in,
    input  logic [WA-1:0] attr_in,
    input  logic          signal_oe,
    output logic [W-1:0]  data_out,
    output logic [WA-1:0] attr_out
);
    localparam int LN = $clog2(N);
    localparam logic [LN:0] NFULL = (LN+1)'(N);

    logic [W-1:0]    slot_data [N];
    logic [WA-1:0]   slot_attr [N];
    logic [N-1:0]    valid;
    logic [LN:0]     wptr;
    logic [LN:0]     wptr_eff;
    logic [LN:0]     wptr_m1;
    logic [SELW-1:0] sel_idx;
    logic [1:0]      mode;
    logic            sel_ok;
    logic            ovf;

    logic            sel_hi;
    logic [LN-1:0]   k;
    logic            in_range;
    logic            need_sel;
    logic            usable;
    logic [W-1:0]    res_data;
    logic [WA-1:0]   res_attr;
    logic            data_wr;

    // A selector index is out of range when any bit above the slot-index bits is set.
    if (SELW > LN) begin : g_hi
        assign sel_hi = |sel_idx[SELW-1:LN];
    end else begin : g_nohi
        assign sel_hi = 1'b0;
    end

    // The output strobe clears the transaction first, so a coincident load starts the next one.
    assign wptr_eff = signal_oe ? '0 : wptr;
    assign wptr_m1  = wptr - (LN+1)'(1);
    assign data_wr  = signal_load && !signal_sel && (wptr_eff < NFULL);

    always_comb begin
        k        = sel_idx[LN-1:0];
        in_range = 1'b1;
        need_sel = 1'b1;
        case (mode)
            2'd0: in_range = !sel_hi;
            2'd1: if (sel_hi) k = LN'(N-1);
            2'd2: begin
                k        = wptr_m1[LN-1:0];
                in_range = (wptr != '0);
                need_sel = 1'b0;
            end
            default: ;
        endcase
        usable   = in_range && valid[k] && (sel_ok || !need_sel);
        res_data = usable ? slot_data[k] : '0;
        res_attr = usable ? slot_attr[k] : WA'(1);
        res_attr[1] = res_attr[1] | ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr    <= '0;
            valid   <= '0;
            sel_idx <= '0;
            mode    <= '0;
            sel_ok  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (signal_oe) begin
                wptr   <= '0;
                valid  <= '0;
                sel_ok <= 1'b0;
                ovf    <= 1'b0;
            end
            if (signal_load) begin
                if (signal_sel) begin
                    sel_idx <= data_in[W-1 -: SELW];
                    mode    <= signal_mode;
                    sel_ok  <= 1'b1;
                end else if (wptr_eff < NFULL) begin
                    valid[wptr_eff[LN-1:0]] <= 1'b1;
                    wptr <= wptr_eff + (LN+1)'(1);
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // Slot contents need no reset: valid[] gates every read.
    always_ff @(posedge clk) begin
        if (data_wr) begin
            slot_data[wptr_eff[LN-1:0]] <= data_in;
            slot_attr[wptr_eff[LN-1:0]] <= attr_in;
        end
    end

`ifdef PU_MUX_N_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out <= '0;
            attr_out <= '0;
        end else if (signal_oe) begin
            data_out <= res_data;
            attr_out <= res_attr;
        end else begin
            data_out <= '0;
            attr_out <= '0;
        end
    end
`else
    assign data_out = signal_oe ? res_data : '0;
    assign attr_out = signal_oe ? res_attr : '0;
`endif

endmodule
